uart_rx: RTL and testbench

Serial receiver paired with the existing UART transmit controller on the `CLOCK_50` domain. It samples the asynchronous `rx` line, recognises 8N1 frames (or 8E1 when parity is compiled in), and presents each received byte with a one-cycle `valid` strobe and per-frame error flags. It shares its bit period with the transmitter, so one link speed serves both directions.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_bit_timer.sv | 44 ++++
 rtl/uart_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants and types shared by the UART receiver and
//               transmitter. Both directions take their bit period from
//               UART_BIT_CLKS_DEFAULT, so a single link speed serves both.
// Contents    : rx_state_e (receiver state encoding)
//               UART_BIT_CLKS_DEFAULT (CLOCK_50 cycles per bit)
//               UART_DATA_BITS (data bits per frame)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_BIT_CLKS_DEFAULT = 43400;
  localparam int UART_DATA_BITS        = 8;

  // PARITY only appears in the receiver when UART_RX_PARITY_EN is defined;
  // the encoding is fixed here so both builds share one type.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Loadable down-counter for UART bit timing. Counts down from
//               the loaded value to zero; expire_o is high while the count
//               is zero, so a reload on expiry gives a period of
//               load_val_i + 1 cycles with no drift.
// Ports       : clk_i      - clock, rising edge
//               rst_ni     - asynchronous active-low reset
//               load_i     - reload the counter with load_val_i
//               load_val_i - value to load (cycles until expiry minus one)
//               expire_o   - count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_CLKS = UART_BIT_CLKS_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_i,
  input  logic [$clog2(BIT_CLKS)-1:0] load_val_i,
  output logic                        expire_o
);

  localparam int c_w = $clog2(BIT_CLKS);

  logic [c_w-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - c_w'(1);
    end
  end

  assign expire_o = (count_q == '0);

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART serial receiver, 8N1 (or 8E1 with UART_RX_PARITY_EN).
//               Synchronises rx, finds the start edge, samples each bit at
//               its centre and presents the byte with a one-cycle valid
//               strobe plus per-frame error flags.
// Macro       : UART_RX_PARITY_EN - adds an even parity bit (11-bit frames)
//               and drives parity_err; otherwise parity_err is tied to 0.
// Ports       : CLOCK_50   - system clock, rising edge
//               Reset_n    - asynchronous active-low reset
//               rx         - serial line, idle high, asynchronous
//               data       - last received byte
//               valid      - one-cycle pulse when data/flags update
//               frame_err  - stop bit of the frame in data was low
//               parity_err - parity mismatch for the frame in data
//               busy       - receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_CLKS = UART_BIT_CLKS_DEFAULT
) (
  input  logic                      CLOCK_50,
  input  logic                      Reset_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      busy
);

  localparam int             c_tw        = $clog2(BIT_CLKS);
  localparam int             c_iw        = $clog2(UART_DATA_BITS);
  // Timer loads are "cycles until next sample minus one".
  localparam logic [c_tw-1:0] c_half_load = c_tw'(BIT_CLKS / 2 - 1);
  localparam logic [c_tw-1:0] c_full_load = c_tw'(BIT_CLKS - 1);
  localparam logic [c_iw-1:0] c_last_idx  = c_iw'(UART_DATA_BITS - 1);

  // --------------------------------------------------------------------------
  // Input synchroniser, reset to the idle-line level so a reset never looks
  // like a start edge by itself.
  // --------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rxs;

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rxs = sync_q[1];

  // --------------------------------------------------------------------------
  // Bit timer
  // --------------------------------------------------------------------------
  logic            tmr_load;
  logic [c_tw-1:0] tmr_val;
  logic            tmr_expire;

  uart_bit_timer #(
    .BIT_CLKS (BIT_CLKS)
  ) u_bit_timer (
    .clk_i      (CLOCK_50),
    .rst_ni     (Reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  rx_state_e                 state_q, state_d;
  logic [c_iw-1:0]           idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                      perr_q, perr_d;
  logic                      par_bad_q, par_bad_d;
`endif

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Every sample point reloads the timer with a full bit
  // period; entry to START loads half a period to land on the bit centre.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q;
    par_bad_d = par_bad_q;
`endif
    tmr_load  = 1'b0;
    tmr_val   = c_full_load;

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d  = START;
          tmr_load = 1'b1;
          tmr_val  = c_half_load;
        end
      end

      START: begin
        if (tmr_expire) begin
          if (!rxs) begin
            state_d  = DATA;
            idx_d    = '0;
            tmr_load = 1'b1;
          end else begin
            // Start bit did not survive to its centre: treat as a glitch.
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (tmr_expire) begin
          shift_d  = {rxs, shift_q[UART_DATA_BITS-1:1]};
          tmr_load = 1'b1;
          if (idx_q == c_last_idx) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + c_iw'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tmr_expire) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = (^shift_q) ^ rxs;
          tmr_load  = 1'b1;
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        if (tmr_expire) begin
          data_d  = shift_q;
          ferr_d  = ~rxs;
          valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_bad_q;
`endif
          // A low stop bit means a break or stuck line; wait for it to
          // return high so it is not taken as the next start edge.
          state_d = rxs ? IDLE : WAIT_HIGH;
        end
      end

      WAIT_HIGH: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx with BIT_CLKS=16. Frames are
//               generated bit by bit on rx; a reference queue holds the byte,
//               expected flags and start cycle of every frame, and a monitor
//               compares each valid pulse against it, including its latency
//               derived from the sample-point timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int B = 16;
  localparam int H = B / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // rx edge -> t0 is 2 cycles, stop sample at t0+H+(FRAME_BITS-1)*B,
  // valid one cycle later.
  localparam int LAT = 3 + H + (FRAME_BITS - 1) * B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(
    .BIT_CLKS (B)
  ) dut (
    .CLOCK_50   (clk),
    .Reset_n    (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   vcyc_q[$];
  int   n_valid    = 0;
  int   n_spurious = 0;
  logic prev_valid = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      vcyc_q.push_back(cyc);
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        n_spurious++;
      end else begin
        mon_e = exp_q.pop_front();
        check("data", {24'd0, data}, {24'd0, mon_e.d});
        check("frame_err", {31'd0, frame_err}, {31'd0, mon_e.fe});
        check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.pe});
        // A bad stop bit leaves the receiver waiting for the line to rise.
        check("busy_at_valid", {31'd0, busy}, {31'd0, mon_e.fe});
        check("latency", cyc - mon_e.start, LAT);
      end
    end
    prev_valid = valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (B) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with rx released high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    exp_t e;
    e.d     = b;
    e.fe    = ~stop_bit;
`ifdef UART_RX_PARITY_EN
    e.pe    = (^b) ^ par_bit;
`else
    e.pe    = 1'b0;
`endif
    e.start = cyc;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int         nv;
    int         n0;
    int         k;
    int         c0;
    logic [7:0] b;
    logic       st;
    logic       perr_inj;
    int         gap;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8'hA5, good stop bit; busy sampled mid-frame
    nv = n_valid;
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        repeat (5 * B) @(negedge clk);
        check("a5_busy_mid", {31'd0, busy}, 32'd1);
      end
    join
    drain(4 * B);
    check("a5_count", n_valid - nv, 32'd1);
    check("a5_busy_after", {31'd0, busy}, 32'd0);

    // 4-cycle low glitch on an idle line
    nv = n_valid;
    c0 = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_rise", {31'd0, busy}, 32'd1);
    k = 0;
    while (busy && k < 4 * B) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_fall_cyc", cyc - c0, 3 + H);
    repeat (2 * B) @(negedge clk);
    check("glitch_no_valid", n_valid - nv, 32'd0);

    // 8'h3C with a low stop bit, line held low 40 more cycles
    nv = n_valid;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("ferr_busy_held", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (2 * FRAME_BITS * B) @(negedge clk);
    drain(4);
    check("ferr_single_valid", n_valid - nv, 32'd1);
    check("ferr_busy_idle", {31'd0, busy}, 32'd0);

    // back-to-back 8'h55, 8'hFF
    n0 = vcyc_q.size();
    send_frame(8'h55, 1'b1, ^8'h55);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    drain(4 * B);
    check("b2b_count", vcyc_q.size() - n0, 32'd2);
    if (vcyc_q.size() >= n0 + 2)
      check("b2b_gap", vcyc_q[n0+1] - vcyc_q[n0], FRAME_BITS * B);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    drain(4 * B);
    send_frame(8'h07, 1'b1, 1'b0);
    drain(4 * B);
`endif

    // reset during bit 4 of 8'h81
    nv = n_valid;
    b  = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (H) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", {24'd0, data}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h42, 1'b1, ^8'h42);
    drain(4 * B);
    check("rst_partial_dropped", n_valid - nv, 32'd1);

    // randomized frames with random gaps, stop errors and parity errors
    for (int n = 0; n < 24; n++) begin
      b        = 8'($urandom);
      st       = ($urandom_range(0, 3) != 0);
      perr_inj = ($urandom_range(0, 3) == 0);
      gap      = st ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
      send_frame(b, st, (^b) ^ perr_inj);
      repeat (gap) @(negedge clk);
    end
    drain(4 * B);

    check("spurious_valid", n_spurious, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
